// File: rtl/ysyx_22040729_mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default bus widths, the
// arbiter FSM state encoding and the encoding of which requester owns
// the outstanding transaction.
package ysyx_22040729_mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 64;
   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned INST_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

endpackage

// File: rtl/ysyx_22040729_rr_arb2.sv
// Two-way round-robin grant for the fetch and LSU requesters.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   req_if_i       fetch requester valid
//   req_lsu_i      LSU requester valid
//   accept_i       the grant shown this cycle is taken (pointer advances)
//   gnt_valid_o    some requester is valid
//   gnt_owner_o    requester that wins this cycle
// The pointer remembers the last granted owner; on a tie the other one
// wins. Out of reset the pointer reads "fetch granted last" so the LSU
// wins the first tie.
module ysyx_22040729_rr_arb2
   import ysyx_22040729_mem_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   req_if_i,
   input  logic   req_lsu_i,
   input  logic   accept_i,
   output logic   gnt_valid_o,
   output owner_e gnt_owner_o
);

   owner_e last_q;
   owner_e last_d;

   always_comb begin
      gnt_valid_o = req_if_i | req_lsu_i;
      gnt_owner_o = OWN_IF;
      if (req_if_i && req_lsu_i) begin
         gnt_owner_o = (last_q == OWN_IF) ? OWN_LSU : OWN_IF;
      end else if (req_lsu_i) begin
         gnt_owner_o = OWN_LSU;
      end
      last_d = (accept_i && gnt_valid_o) ? gnt_owner_o : last_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= OWN_IF;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ysyx_22040729_mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and the LSU.
// Exactly one transaction is in flight: IDLE grants and captures the
// request, REQ presents it to memory until accepted, RESP waits for the
// memory response and forwards it to the owner in the same cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req_* / if_resp_*     fetch request / response (INST_W data)
//   lsu_req_* / lsu_resp_*   load/store request / response
//   mem_req_* / mem_resp_*   shared memory port
//   err_stray                sticky: memory response seen outside RESP
module ysyx_22040729_mem_arbiter
   import ysyx_22040729_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned INST_W = INST_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_valid,
   output logic                  if_req_ready,
   input  logic [ADDR_W-1:0]     if_req_addr,
   output logic                  if_resp_valid,
   output logic [INST_W-1:0]     if_resp_data,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_W-1:0]     lsu_req_addr,
   input  logic                  lsu_req_wen,
   input  logic [DATA_W-1:0]     lsu_req_wdata,
   input  logic [DATA_W/8-1:0]   lsu_req_wmask,
   output logic                  lsu_resp_valid,
   output logic [DATA_W-1:0]     lsu_resp_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_req_addr,
   output logic                  mem_req_wen,
   output logic [DATA_W-1:0]     mem_req_wdata,
   output logic [DATA_W/8-1:0]   mem_req_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_resp_rdata,
   output logic                  err_stray
);

   localparam int unsigned MASK_W = DATA_W / 8;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic                err_q, err_d;

   logic                gnt_valid;
   owner_e              gnt_owner;

   ysyx_22040729_rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_if_i    (if_req_valid),
      .req_lsu_i   (lsu_req_valid),
      .accept_i    (state_q == ST_IDLE),
      .gnt_valid_o (gnt_valid),
      .gnt_owner_o (gnt_owner)
   );

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      addr_d         = addr_q;
      wen_d          = wen_q;
      wdata_d        = wdata_q;
      wmask_d        = wmask_q;
      if_req_ready   = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      if_resp_valid  = 1'b0;
      if_resp_data   = '0;
      lsu_resp_valid = 1'b0;
      lsu_resp_rdata = '0;
      // Anything arriving from memory while no response is expected is
      // dropped and latched as an error.
      err_d          = err_q | (mem_resp_valid && (state_q != ST_RESP));

      case (state_q)
         ST_IDLE: begin
            // Readies are gated by rst so they drop the moment reset is
            // applied, not only at the next edge.
            if (gnt_valid && rst) begin
               owner_d = gnt_owner;
               state_d = ST_REQ;
               if (gnt_owner == OWN_LSU) begin
                  lsu_req_ready = 1'b1;
                  addr_d        = lsu_req_addr;
                  wen_d         = lsu_req_wen;
                  wdata_d       = lsu_req_wdata;
                  wmask_d       = lsu_req_wmask;
               end else begin
                  if_req_ready  = 1'b1;
                  addr_d        = if_req_addr;
                  wen_d         = 1'b0;
                  wdata_d       = '0;
                  wmask_d       = '0;
               end
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_resp_valid) begin
               state_d = ST_IDLE;
               if (owner_q == OWN_IF) begin
                  if_resp_valid = 1'b1;
                  // Byte address bit 2 selects the upper instruction word.
                  if_resp_data  = addr_q[2] ? mem_resp_rdata[2*INST_W-1 -: INST_W]
                                            : mem_resp_rdata[INST_W-1:0];
               end else begin
                  lsu_resp_valid = 1'b1;
                  lsu_resp_rdata = wen_q ? '0 : mem_resp_rdata;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         err_q   <= err_d;
      end
   end

   assign mem_req_addr  = addr_q;
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;
   assign err_stray     = err_q;

endmodule

// File: tb/tb_ysyx_22040729_mem_arbiter.sv
module tb_ysyx_22040729_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [63:0] if_req_addr = '0;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        lsu_req_valid = 1'b0;
   logic        lsu_req_ready;
   logic [63:0] lsu_req_addr = '0;
   logic        lsu_req_wen = 1'b0;
   logic [63:0] lsu_req_wdata = '0;
   logic [7:0]  lsu_req_wmask = '0;
   logic        lsu_resp_valid;
   logic [63:0] lsu_resp_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_resp_rdata = '0;
   logic        err_stray;

   int n_pass = 0;
   int n_total = 0;

   // sim_mem is what the bench memory serves, driven by the DUT's request
   // fields; ref_mem is the model, updated from the requests the bench issued.
   logic [63:0] sim_mem [16];
   logic [63:0] ref_mem [16];

   always #5 clk = ~clk;

   ysyx_22040729_mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_req_addr    (if_req_addr),
      .if_resp_valid  (if_resp_valid),
      .if_resp_data   (if_resp_data),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_req_addr   (lsu_req_addr),
      .lsu_req_wen    (lsu_req_wen),
      .lsu_req_wdata  (lsu_req_wdata),
      .lsu_req_wmask  (lsu_req_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_rdata (lsu_resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .err_stray      (err_stray)
   );

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] wm);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) begin
         if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   task automatic clear_inputs();
      if_req_valid   = 1'b0;
      lsu_req_valid  = 1'b0;
      lsu_req_wen    = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Runs one request through grant, memory handshake and response. Ends in
   // the response cycle (mem_resp_valid still high until the next negedge).
   // clean=0 if any cycle showed readies/resp/data outside their window or
   // unstable memory request fields.
   task automatic txn(input bit if_v, input logic [63:0] if_a, input bit lsu_v,
                      input logic [63:0] lsu_a, input bit wen, input logic [63:0] wd,
                      input logic [7:0] wm, input int rdy_dly, input int rsp_dly,
                      input bit hold, output bit ok, output bit gl,
                      output logic [63:0] f_addr, output bit f_wen,
                      output logic [63:0] f_wdata, output logic [7:0] f_wmask,
                      output bit clean, output bit r_if, output bit r_lsu,
                      output logic [31:0] idata, output logic [63:0] ldata, output int lat);
      int n;
      bit done;
      logic [63:0] rd;
      logic [3:0] idx;
      ok = 0; gl = 0; clean = 1; r_if = 0; r_lsu = 0; idata = '0; ldata = '0; lat = 0;
      f_addr = '0; f_wen = 0; f_wdata = '0; f_wmask = '0;
      @(negedge clk);
      if_req_valid = if_v; if_req_addr = if_a;
      lsu_req_valid = lsu_v; lsu_req_addr = lsu_a; lsu_req_wen = wen;
      lsu_req_wdata = wd; lsu_req_wmask = wm;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'hA5A5_5A5A_C3C3_3C3C;
      #1;
      n = 0;
      while (!(if_req_ready || lsu_req_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) return;
      if (if_req_ready && lsu_req_ready) clean = 0;
      gl = lsu_req_ready;
      done = 0; n = 0;
      while (!done && n < 30) begin
         @(negedge clk); lat++;
         if (!hold) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
         mem_req_ready = (n >= rdy_dly);
         #1;
         if (n == 0) begin
            f_addr = mem_req_addr; f_wen = mem_req_wen;
            f_wdata = mem_req_wdata; f_wmask = mem_req_wmask;
         end else if (mem_req_addr !== f_addr || mem_req_wen !== f_wen ||
                      mem_req_wdata !== f_wdata || mem_req_wmask !== f_wmask) begin
            clean = 0;
         end
         if (!mem_req_valid || if_req_ready || lsu_req_ready || if_resp_valid ||
             lsu_resp_valid || if_resp_data !== 32'h0 || lsu_resp_rdata !== 64'h0) clean = 0;
         if (mem_req_valid && mem_req_ready) done = 1;
         n++;
      end
      if (!done) return;
      idx = mem_req_addr[6:3];
      rd = sim_mem[idx];
      if (mem_req_wen) sim_mem[idx] = merge(rd, mem_req_wdata, mem_req_wmask);
      done = 0; n = 0;
      while (!done && n <= rsp_dly) begin
         @(negedge clk); lat++;
         mem_req_ready = 1'b0;
         mem_resp_valid = (n == rsp_dly);
         mem_resp_rdata = mem_resp_valid ? rd : 64'h5A5A_A5A5_3C3C_C3C3;
         #1;
         if (if_req_ready || lsu_req_ready || mem_req_valid) clean = 0;
         if (mem_resp_valid) begin
            r_if = if_resp_valid; r_lsu = lsu_resp_valid;
            idata = if_resp_data; ldata = lsu_resp_rdata;
            done = 1;
         end else if (if_resp_valid || lsu_resp_valid || if_resp_data !== 32'h0 ||
                      lsu_resp_rdata !== 64'h0) begin
            clean = 0;
         end
         n++;
      end
      ok = done;
   endtask

   // txn outputs shared by the tests
   bit ok, gl, f_wen, clean, r_if, r_lsu;
   logic [63:0] f_addr, f_wdata, ldata;
   logic [7:0] f_wmask;
   logic [31:0] idata;
   int lat;

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      if_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_resp_valid = 1'b1;
      #1;
      n_total++; if (if_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) $display("FAIL reset_ready: if=%b lsu=%b want 0 0", if_req_ready, lsu_req_ready); else n_pass++;
      n_total++; if (mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) $display("FAIL reset_valid: mem=%b if=%b lsu=%b want 0", mem_req_valid, if_resp_valid, lsu_resp_valid); else n_pass++;
      n_total++; if (mem_req_addr !== 64'h0 || mem_req_wmask !== 8'h0 || mem_req_wdata !== 64'h0 || mem_req_wen !== 1'b0) $display("FAIL reset_fields: addr=%h wmask=%h want 0", mem_req_addr, mem_req_wmask); else n_pass++;
      n_total++; if (err_stray !== 1'b0) $display("FAIL reset_err: got %b want 0", err_stray); else n_pass++;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_fetch();
      sim_mem[0] = 64'h1111_2222_3333_4444;
      ref_mem[0] = 64'h1111_2222_3333_4444;
      txn(1, 64'h8000_0004, 0, '0, 0, '0, '0, 0, 0, 0, ok, gl, f_addr, f_wen, f_wdata, f_wmask, clean, r_if, r_lsu, idata, ldata, lat);
      n_total++; if (!ok) $display("FAIL fetch_timeout: no handshake/response"); else n_pass++;
      n_total++; if (gl !== 1'b0 || f_addr !== 64'h8000_0004 || f_wen !== 1'b0 || f_wmask !== 8'h0) $display("FAIL fetch_req: lsu_gnt=%b addr=%h wen=%b wmask=%h want 0 80000004 0 00", gl, f_addr, f_wen, f_wmask); else n_pass++;
      n_total++; if (r_if !== 1'b1 || r_lsu !== 1'b0 || idata !== 32'h1111_2222) $display("FAIL fetch_resp: if_v=%b lsu_v=%b data=%h want 1 0 11112222", r_if, r_lsu, idata); else n_pass++;
      n_total++; if (lat !== 2 || !clean) $display("FAIL fetch_latency: lat=%0d clean=%b want 2 1", lat, clean); else n_pass++;
      idle_cycle();
      #1;
      n_total++; if (if_resp_valid !== 1'b0) $display("FAIL fetch_one_cycle: if_resp_valid=%b want 0", if_resp_valid); else n_pass++;
   endtask

   task automatic test_priority();
      bit model_last_lsu;
      do_reset();
      model_last_lsu = 0;
      for (int i = 0; i < 5; i++) begin
         bit exp_lsu;
         exp_lsu = !model_last_lsu;
         model_last_lsu = exp_lsu;
         txn(1, 64'h8000_0020, 1, 64'h8000_0028, 0, '0, 8'hFF, 0, 0, 1, ok, gl, f_addr, f_wen, f_wdata, f_wmask, clean, r_if, r_lsu, idata, ldata, lat);
         n_total++; if (!ok || gl !== exp_lsu || r_lsu !== exp_lsu || r_if !== !exp_lsu || !clean) $display("FAIL rr_grant[%0d]: ok=%b lsu_gnt=%b resp_lsu=%b clean=%b want lsu_gnt=%b", i, ok, gl, r_lsu, clean, exp_lsu); else n_pass++;
      end
      idle_cycle();
   endtask

   task automatic test_store();
      txn(0, '0, 1, 64'h8000_0010, 1, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 0, ok, gl, f_addr, f_wen, f_wdata, f_wmask, clean, r_if, r_lsu, idata, ldata, lat);
      ref_mem[2] = merge(ref_mem[2], 64'h0000_0000_DEAD_BEEF, 8'h0F);
      n_total++; if (!ok || f_addr !== 64'h8000_0010 || f_wen !== 1'b1 || f_wdata !== 64'hDEAD_BEEF || f_wmask !== 8'h0F) $display("FAIL store_req: addr=%h wen=%b wdata=%h wmask=%h want 80000010 1 deadbeef 0f", f_addr, f_wen, f_wdata, f_wmask); else n_pass++;
      n_total++; if (r_lsu !== 1'b1 || r_if !== 1'b0 || ldata !== 64'h0 || !clean) $display("FAIL store_resp: lsu_v=%b if_v=%b rdata=%h clean=%b want 1 0 0 1", r_lsu, r_if, ldata, clean); else n_pass++;
      idle_cycle();
   endtask

   task automatic test_stall();
      txn(0, '0, 1, 64'h8000_0010, 0, 64'h1234, 8'hAA, 5, 0, 1, ok, gl, f_addr, f_wen, f_wdata, f_wmask, clean, r_if, r_lsu, idata, ldata, lat);
      n_total++; if (!ok || !clean) $display("FAIL stall_stable: ok=%b clean=%b want 1 1", ok, clean); else n_pass++;
      n_total++; if (f_addr !== 64'h8000_0010 || f_wen !== 1'b0 || lat !== 7) $display("FAIL stall_fields: addr=%h wen=%b lat=%0d want 80000010 0 7", f_addr, f_wen, lat); else n_pass++;
      n_total++; if (r_lsu !== 1'b1 || ldata !== ref_mem[2]) $display("FAIL stall_load: lsu_v=%b rdata=%h want 1 %h", r_lsu, ldata, ref_mem[2]); else n_pass++;
      idle_cycle();
   endtask

   task automatic test_random();
      bit model_last_lsu;
      do_reset();
      model_last_lsu = 0;
      for (int i = 0; i < 40; i++) begin
         int sel, rdy, rsp;
         bit ifv, lsuv, wen, hi, exp_lsu, hold;
         logic [3:0] iidx, lidx, eidx;
         logic [63:0] ia, la, wd, ea, exp_ld;
         logic [7:0] wm;
         logic [31:0] exp_i;
         sel = $urandom_range(0, 2);
         ifv = (sel != 1); lsuv = (sel != 0);
         iidx = 4'($urandom_range(0, 15)); lidx = 4'($urandom_range(0, 15));
         hi = 1'($urandom_range(0, 1));
         ia = 64'h8000_0000 | (64'(iidx) << 3) | (64'(hi) << 2);
         la = 64'h8000_0000 | (64'(lidx) << 3);
         wen = 1'($urandom_range(0, 1));
         wd = {$urandom, $urandom};
         wm = 8'($urandom_range(0, 255));
         rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
         hold = 1'($urandom_range(0, 1));
         exp_lsu = (ifv && lsuv) ? !model_last_lsu : lsuv;
         model_last_lsu = exp_lsu;
         ea = exp_lsu ? la : ia;
         eidx = exp_lsu ? lidx : iidx;
         exp_ld = (exp_lsu && wen) ? 64'h0 : ref_mem[eidx];
         exp_i = hi ? ref_mem[eidx][63:32] : ref_mem[eidx][31:0];
         txn(ifv, ia, lsuv, la, wen, wd, wm, rdy, rsp, hold, ok, gl, f_addr, f_wen, f_wdata, f_wmask, clean, r_if, r_lsu, idata, ldata, lat);
         if (exp_lsu && wen) ref_mem[eidx] = merge(ref_mem[eidx], wd, wm);
         n_total++; if (!ok) begin $display("FAIL rand_timeout[%0d]: no handshake/response", i); break; end else n_pass++;
         n_total++; if (gl !== exp_lsu || f_addr !== ea) $display("FAIL rand_grant[%0d]: lsu_gnt=%b addr=%h want %b %h", i, gl, f_addr, exp_lsu, ea); else n_pass++;
         n_total++; if (f_wen !== (exp_lsu && wen) || (exp_lsu && wen && (f_wdata !== wd || f_wmask !== wm)) || (!exp_lsu && (f_wdata !== 64'h0 || f_wmask !== 8'h0))) $display("FAIL rand_fields[%0d]: wen=%b wdata=%h wmask=%h", i, f_wen, f_wdata, f_wmask); else n_pass++;
         if (exp_lsu) begin
            n_total++; if (r_lsu !== 1'b1 || r_if !== 1'b0 || ldata !== exp_ld) $display("FAIL rand_lsu_resp[%0d]: v=%b if_v=%b rdata=%h want 1 0 %h", i, r_lsu, r_if, ldata, exp_ld); else n_pass++;
         end else begin
            n_total++; if (r_if !== 1'b1 || r_lsu !== 1'b0 || idata !== exp_i) $display("FAIL rand_if_resp[%0d]: v=%b lsu_v=%b data=%h want 1 0 %h", i, r_if, r_lsu, idata, exp_i); else n_pass++;
         end
         n_total++; if (!clean || lat !== 2 + rdy + rsp) $display("FAIL rand_timing[%0d]: clean=%b lat=%0d want 1 %0d", i, clean, lat, 2 + rdy + rsp); else n_pass++;
      end
      idle_cycle();
      #1;
      n_total++; if (err_stray !== 1'b0) $display("FAIL rand_no_stray: err_stray=%b want 0", err_stray); else n_pass++;
   endtask

   task automatic test_stray();
      @(negedge clk);
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_0000_FFFF_0000;
      #1;
      n_total++; if (if_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || lsu_resp_rdata !== 64'h0) $display("FAIL stray_resp: if_v=%b lsu_v=%b rdata=%h want 0 0 0", if_resp_valid, lsu_resp_valid, lsu_resp_rdata); else n_pass++;
      idle_cycle();
      #1;
      n_total++; if (err_stray !== 1'b1) $display("FAIL stray_set: err_stray=%b want 1", err_stray); else n_pass++;
      txn(1, 64'h8000_0000, 0, '0, 0, '0, '0, 1, 1, 0, ok, gl, f_addr, f_wen, f_wdata, f_wmask, clean, r_if, r_lsu, idata, ldata, lat);
      n_total++; if (!ok || r_if !== 1'b1 || idata !== ref_mem[0][31:0]) $display("FAIL stray_then_fetch: ok=%b v=%b data=%h want 1 1 %h", ok, r_if, idata, ref_mem[0][31:0]); else n_pass++;
      idle_cycle();
      #1;
      n_total++; if (err_stray !== 1'b1) $display("FAIL stray_sticky: err_stray=%b want 1", err_stray); else n_pass++;
      do_reset();
      #1;
      n_total++; if (err_stray !== 1'b0) $display("FAIL stray_clear: err_stray=%b want 0", err_stray); else n_pass++;
   endtask

   task automatic test_reset_mid();
      // Reset while in REQ: request must vanish immediately.
      @(negedge clk);
      lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0018; lsu_req_wen = 1'b0;
      @(negedge clk);
      lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
      #1;
      n_total++; if (mem_req_valid !== 1'b1) $display("FAIL mid_req_setup: mem_req_valid=%b want 1", mem_req_valid); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) $display("FAIL mid_req_reset: valid=%b addr=%h want 0 0", mem_req_valid, mem_req_addr); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      // Reset while in RESP with the response arriving: nothing delivered.
      @(negedge clk);
      lsu_req_valid = 1'b1;
      @(negedge clk);
      lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
      rst = 1'b0;
      #1;
      n_total++; if (lsu_resp_valid !== 1'b0 || if_resp_valid !== 1'b0 || lsu_resp_rdata !== 64'h0 || mem_req_valid !== 1'b0 || err_stray !== 1'b0) $display("FAIL mid_resp_reset: lsu_v=%b if_v=%b rdata=%h mem_v=%b err=%b want all 0", lsu_resp_valid, if_resp_valid, lsu_resp_rdata, mem_req_valid, err_stray); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++; if (lsu_resp_valid !== 1'b0 || if_resp_valid !== 1'b0) $display("FAIL post_reset_resp: lsu_v=%b if_v=%b want 0 0", lsu_resp_valid, if_resp_valid); else n_pass++;
      idle_cycle();
      #1;
      n_total++; if (err_stray !== 1'b1) $display("FAIL post_reset_stray: err_stray=%b want 1", err_stray); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         sim_mem[i] = {$urandom, $urandom};
         ref_mem[i] = sim_mem[i];
      end
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_stall();
      test_random();
      test_stray();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ysyx_22040729_mem_arbiter.md
YSYX_22040729_MEM_ARBITER -- requirements
Module: ysyx_22040729_mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 64, address width; DATA_W, default 64, memory data width; INST_W, default 32, fetch data width.
REQ-002 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_resp_valid  out  1  fetch data valid, one cycle.
- if_resp_data  out  INST_W  instruction word.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_addr  in  ADDR_W  LSU byte address.
- lsu_req_wen  in  1  1 = store.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_wmask  in  DATA_W/8  byte strobes.
- lsu_resp_valid  out  1  load data / store ack, one cycle.
- lsu_resp_rdata  out  DATA_W  load data; 0 for stores.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W.
- mem_req_wen  out  1.
- mem_req_wdata  out  DATA_W.
- mem_req_wmask  out  DATA_W/8; all-zero for fetch.
- mem_resp_valid  in  1  memory response.
- mem_resp_rdata  in  DATA_W.
- err_stray  out  1  sticky: mem_resp_valid seen outside RESP.

Function
REQ-003 FSM states IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-004 IDLE: when any requester is valid, grant one, assert only its req_ready for that cycle, capture addr/wen/wdata/wmask and owner into registers, go REQ.
REQ-005 Arbitration: single request wins; both valid -> winner is requester not granted last (round-robin pointer); pointer after reset favours LSU.
REQ-006 if_req_ready and lsu_req_ready never both 1; both 0 outside IDLE.
REQ-007 REQ: mem_req_valid=1 with registered fields held stable until mem_req_ready; on handshake go RESP.
REQ-008 RESP: wait for mem_resp_valid; same cycle assert owner's resp_valid combinationally, go IDLE.
REQ-009 Fetch data: if_resp_data = mem_resp_rdata[63:32] when captured addr[2]=1, else [31:0].
REQ-010 LSU store response: lsu_resp_valid=1, lsu_resp_rdata=0.
REQ-011 Latency: accept to response minimum 2 cycles (mem_req_ready and mem_resp_valid both immediate); next grant no earlier than cycle after response.
REQ-012 mem_resp_valid in IDLE or REQ: ignored, sets err_stray; cleared only by reset.
REQ-013 Requester dropping valid while not granted: no effect, no transaction.
REQ-014 Outputs in IDLE/REQ: resp_valid=0, resp data=0.

Reset
REQ-015 rst=0: state IDLE, pointer favours LSU, all captured registers 0, err_stray=0, all valid/ready outputs 0, asynchronously.
REQ-016 Reset mid-REQ/RESP: transaction abandoned, no response delivered; first post-reset memory response sets err_stray.

Structure
REQ-017 Shared package: FSM state enum, owner encoding (OWN_IF, OWN_LSU), ADDR_W/DATA_W defaults.
REQ-018 One sub-module: ysyx_22040729_rr_arb2 (2-way round-robin grant + pointer register).

Verification
REQ-019 Fetch only: if_req addr 0x80000004, mem returns 0x11112222_33334444 -> if_resp_data 0x11112222, one-cycle if_resp_valid.
REQ-020 Simultaneous IF+LSU after reset -> LSU granted first, IF second; repeat both held -> grants alternate IF, LSU, IF.
REQ-021 Store addr 0x80000010, wdata 0xDEADBEEF, wmask 0x0F -> mem_req fields match, lsu_resp_valid with rdata 0.
REQ-022 mem_req_ready held 0 for 5 cycles -> mem_req fields stable, both req_ready 0 throughout.
REQ-023 Stray mem_resp_valid in IDLE -> err_stray=1, no resp_valid; stays 1 until rst.
REQ-024 rst low during RESP -> all outputs 0 immediately; no response after release.
